// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin two-client arbiter/sequencer for the shared ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [WIDTH-1:0] req_a0_i,
    input  logic [WIDTH-1:0] req_b0_i,
    input  logic [3:0]       req_op0_i,
    input  logic [WIDTH-1:0] req_a1_i,
    input  logic [WIDTH-1:0] req_b1_i,
    input  logic [3:0]       req_op1_i,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [3:0]       alu_op_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_zero_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic             rsp_zero_o,
    output logic             rsp_err_o
);

    localparam logic [3:0] c_OP_ADD = 4'b1001;
    localparam logic [3:0] c_OP_SUB = 4'b1010;
    localparam logic [3:0] c_OP_AND = 4'b1011;
    localparam logic [3:0] c_OP_OR  = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               prio_q, prio_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [3:0]         op_q, op_d;
    logic               id_q, id_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;
    logic               grant;
    logic               op_supported;

    assign op_supported = (op_q == c_OP_ADD) || (op_q == c_OP_SUB) ||
                          (op_q == c_OP_AND) || (op_q == c_OP_OR);

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        op_d        = op_q;
        id_d        = id_q;
        res_d       = res_q;
        zero_d      = zero_q;
        err_d       = err_q;
        grant       = prio_q;
        req_ready_o = 2'b00;
        alu_a_o     = '0;
        alu_b_o     = '0;
        alu_op_o    = 4'b0000;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i == 2'b01) begin
                    grant = 1'b0;
                end else if (req_valid_i == 2'b10) begin
                    grant = 1'b1;
                end
                if (|req_valid_i && !reset_i) begin
                    req_ready_o = grant ? 2'b10 : 2'b01;
                    opa_d       = grant ? req_a1_i  : req_a0_i;
                    opb_d       = grant ? req_b1_i  : req_b0_i;
                    op_d        = grant ? req_op1_i : req_op0_i;
                    id_d        = grant;
                    state_d     = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!reset_i) begin
                    alu_a_o  = opa_q;
                    alu_b_o  = opb_q;
                    alu_op_o = op_q;
                end
                // Unsupported codes force a fixed, ALU-independent response.
                res_d   = op_supported ? alu_result_i : '0;
                zero_d  = op_supported ? alu_zero_i   : 1'b1;
                err_d   = !op_supported;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    prio_d  = ~id_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            op_q    <= 4'b0000;
            id_q    <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            id_q    <= id_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid_o  = (state_q == S_RESP);
    assign rsp_id_o     = id_q;
    assign rsp_result_o = res_q;
    assign rsp_zero_o   = zero_q;
    assign rsp_err_o    = err_q;

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared ALU datapath. It accepts operation requests (operands plus 4-bit ALU operation code) from two clients over valid/ready handshakes. It grants one request at a time by round-robin priority, drives the ALU for one execute cycle, and registers the result and Zero flag. It then returns them on a single response channel tagged with the requester ID. It sits between the ALU and its clients (for example, the execute stage and the address/branch unit).

## Interface
Parameters:
- WIDTH, 32, operand/result width; must match ALU width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; at most one bit high.
- req_a0, req_b0  in  WIDTH each  requester 0 operands.
- req_op0  in  4  requester 0 operation code.
- req_a1, req_b1  in  WIDTH each  requester 1 operands.
- req_op1  in  4  requester 1 operation code.
- alu_a, alu_b  out  WIDTH each  operands to the ALU.
- alu_op  out  4  ALUOperation to the ALU.
- alu_result  in  WIDTH  ALU result.
- alu_zero  in  1  ALU Zero flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  WIDTH  registered result.
- rsp_zero  out  1  registered Zero flag.
- rsp_err  out  1  high when the captured opcode was unsupported.

## Operation
- Supported opcodes: 4'b1001 ADD, 4'b1010 SUB, 4'b1011 AND, 4'b1100 OR. All other codes are unsupported.
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE
  - Arbitration: if only one req_valid bit is set, grant that requester. If both are set, grant requester `prio`.
  - req_ready = one-hot of the grant. It is combinational from state, prio and req_valid.
  - On a handshake edge (req_valid[i] & req_ready[i]): capture a, b, op and id=i into operand registers, then go to EXEC.
- EXEC
  - alu_a, alu_b and alu_op are driven from the operand registers.
  - At the edge: capture alu_result into rsp_result and alu_zero into rsp_zero, set rsp_err, then go to RESP.
  - If the opcode is unsupported: rsp_err=1, rsp_result=0, rsp_zero=1, regardless of the ALU inputs.
- RESP
  - rsp_valid=1. rsp_id, rsp_result, rsp_zero and rsp_err are held stable.
  - On an edge with rsp_ready=1: go to IDLE and set prio = ~rsp_id.
  - If rsp_ready=0: stay in RESP indefinitely.
- Outside EXEC: alu_op=4'b0000 and alu_a=alu_b=0. The ALU therefore produces 0 and is idle.
- req_ready=0 in EXEC and RESP; no request is accepted while busy.
- Round-robin guarantee: with both requesters continuously valid, grants alternate 0,1,0,1...
- Operand widths are exactly WIDTH; no extension or saturation. Overflow is the ALU's concern (wrap-around).

## Timing
- Reset values: state=IDLE, prio=0, req_ready=0 while reset asserted. Also rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, alu_a=alu_b=0, alu_op=0.
- Reset asserted in any state returns to IDLE on the next edge. Any in-flight request is discarded with no response issued.
- Latency: request accepted at edge N; ALU driven during cycle N..N+1. rsp_valid is high after edge N+1. With rsp_ready held high, the handshake completes at edge N+2.
- Throughput: at most one operation per 3 cycles.
- After edge N+2, IDLE can accept a new request at edge N+3.
- rsp_result, rsp_zero, rsp_err and rsp_id are registered. They do not change while rsp_valid=1.
- A request deasserted before being granted is simply not served; no state is retained for it.
- req_* inputs are don't-care outside the handshake cycle.

## Test plan
- Single request, ADD: requester 0 sends a=5, b=7, op=1001 with rsp_ready=1. Expect req_ready[0] in that cycle, alu_op=1001 for exactly one cycle, then rsp_valid with id=0, result=12, zero=0, err=0, 2 cycles after acceptance.
- SUB giving zero: requester 1 sends a=9, b=9, op=1010. Expect rsp_result=0, rsp_zero=1, rsp_id=1.
- Contention: both requesters valid continuously from reset, with requester 0 op=1011 (AND) and requester 1 op=1100 (OR), a=0xF0F0, b=0x0FF0. Expect grant order 0,1,0,1, with responses 0x00F0 (id 0) and 0xFFF0 (id 1).
- Backpressure: hold rsp_ready=0 for 5 cycles. Expect rsp_valid and all rsp fields stable, req_ready=0 throughout, and completion on the first edge with rsp_ready=1.
- Unsupported opcode: op=0111, a=3, b=1. Expect rsp_err=1, rsp_result=0, rsp_zero=1.
- Reset mid-operation: assert reset in EXEC and again in RESP. Expect IDLE next cycle, rsp_valid=0, prio=0, and no response for the dropped request.
